// File: rtl/pp_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
package pp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding keeps ACCUM alone on bit 0 so the generator enable is a single flop.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/pp_acc_reg.sv
// 2*WIDTH-bit accumulator: adds the zero-extended partial-product row shifted by idx.
module pp_acc_reg
    import pp_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IW    = idx_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [WIDTH-1:0]     pp_row,
    input  logic [IW-1:0]        idx,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_addend;

    assign w_addend = {{WIDTH{1'b0}}, pp_row} << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (clr)
            r_acc <= '0;
        else if (en)
            r_acc <= r_acc + w_addend;
    end

    assign acc = r_acc;

endmodule

// File: rtl/pp_accum_seq.sv
// Sequencer that walks multiplier bits through an external partial-product row
// and accumulates the returned rows into a 2*WIDTH-bit product.
module pp_accum_seq
    import pp_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IW    = idx_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     pp_a,
    output logic                 pp_b,
    output logic                 ppgen_en,
    output logic                 ppgen_en_bar,
    input  logic [WIDTH-1:0]     pp_row
);

    state_e             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IW-1:0]      r_idx;

    logic               w_accept;
    logic               w_accum;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_accum  = r_state[0];
    assign w_last   = (r_idx == IW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= '0;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_last)
                        r_state <= ST_DONE;
                    else
                        r_idx <= r_idx + IW'(1);
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // pp_row may float when the row is disabled, so only ACCUM enables the add.
    pp_acc_reg #(.WIDTH(WIDTH)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_accept),
        .en     (w_accum),
        .pp_row (pp_row),
        .idx    (r_idx),
        .acc    (w_acc)
    );

    assign ready        = (r_state == ST_IDLE);
    assign busy         = w_accum;
    assign done         = (r_state == ST_DONE);
    assign product      = w_acc;
    assign pp_a         = r_a;
    assign pp_b         = w_accum & r_b[r_idx];
    assign ppgen_en     = w_accum;
    assign ppgen_en_bar = ~w_accum;

endmodule

// File: tb/tb_pp_accum_seq.sv
// Directed bench for pp_accum_seq with a behavioural partial-product row.
module tb_pp_accum_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        ready, busy, done;
    logic [15:0] product;
    logic [7:0]  pp_a;
    logic        pp_b;
    logic        ppgen_en, ppgen_en_bar;
    logic [7:0]  pp_row;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Garbage while disabled so any sampling outside ACCUM corrupts the product.
    always_comb pp_row = ppgen_en ? (pp_a & {8{pp_b}}) : 8'h5A;

    pp_accum_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a),
        .b            (b),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .pp_a         (pp_a),
        .pp_b         (pp_b),
        .ppgen_en     (ppgen_en),
        .ppgen_en_bar (ppgen_en_bar),
        .pp_row       (pp_row)
    );

    // Drives one multiply from IDLE; lat counts the cycle after the accepting edge as 1.
    task automatic do_mul(input logic [7:0] ta, input logic [7:0] bv,
                          output int lat, output logic [15:0] prod,
                          output logic [7:0] pbs, output int en_bad,
                          output int accum_cyc);
        int k;
        k = 0; lat = -1; prod = '0; pbs = '0; en_bad = 0; accum_cyc = 0;
        @(negedge clk);
        a = ta; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~bv;
        for (int n = 1; n <= 40; n++) begin
            if (ppgen_en_bar !== ~ppgen_en) en_bad++;
            if (ppgen_en) begin
                if (k < 8) pbs[k] = pp_b;
                k++;
                accum_cyc++;
            end
            if (done) begin
                lat = n;
                prod = product;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        checks++; if (product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
        checks++; if (ppgen_en !== 1'b0 || ppgen_en_bar !== 1'b1) begin errors++; $display("FAIL reset_en: got en=%b bar=%b expected 0/1", ppgen_en, ppgen_en_bar); end
        checks++; if (pp_a !== 8'h0 || pp_b !== 1'b0) begin errors++; $display("FAIL reset_pp: got pp_a=%h pp_b=%b expected 00/0", pp_a, pp_b); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got ready=%b busy=%b expected 1/0", ready, busy); end
    endtask

    task automatic test_ff;
        int lat, eb, ac; logic [15:0] p; logic [7:0] pbs;
        do_mul(8'hFF, 8'hFF, lat, p, pbs, eb, ac);
        checks++; if (lat !== 9) begin errors++; $display("FAIL ff_latency: got %0d expected 9", lat); end
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL ff_product: got %h expected fe01", p); end
        checks++; if (ac !== 8) begin errors++; $display("FAIL ff_accum_cycles: got %0d expected 8", ac); end
        @(negedge clk);
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ff_back_idle: got ready=%b done=%b expected 1/0", ready, done); end
        checks++; if (product !== 16'hFE01) begin errors++; $display("FAIL ff_hold: got %h expected fe01", product); end
    endtask

    task automatic test_0d0b;
        int lat, eb, ac; logic [15:0] p; logic [7:0] pbs;
        do_mul(8'h0D, 8'h0B, lat, p, pbs, eb, ac);
        checks++; if (p !== 16'h008F) begin errors++; $display("FAIL d_b_product: got %h expected 008f", p); end
        // pbs[0] is the first bit broadcast: 1,1,0,1,0,0,0,0
        checks++; if (pbs !== 8'b0000_1011) begin errors++; $display("FAIL d_b_ppb_seq: got %b expected 00001011", pbs); end
        checks++; if (eb !== 0) begin errors++; $display("FAIL d_b_en_bar: got %0d bad cycles expected 0", eb); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL d_b_latency: got %0d expected 9", lat); end
    endtask

    task automatic test_zero;
        int lat, eb, ac; logic [15:0] p; logic [7:0] pbs;
        do_mul(8'h00, 8'hA5, lat, p, pbs, eb, ac);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_a_product: got %h expected 0000", p); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL zero_a_latency: got %0d expected 9", lat); end
        do_mul(8'hA5, 8'h00, lat, p, pbs, eb, ac);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_b_product: got %h expected 0000", p); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL zero_b_latency: got %0d expected 9", lat); end
        checks++; if (pbs !== 8'h00) begin errors++; $display("FAIL zero_b_ppb_seq: got %b expected 00000000", pbs); end
    endtask

    task automatic test_ignore_start;
        int lat;
        lat = -1;
        @(negedge clk);
        a = 8'h0D; b = 8'h0B; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin lat = n; break; end
            if (n == 3) begin a = 8'hFF; b = 8'hFF; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
        end
        checks++; if (lat !== 9) begin errors++; $display("FAIL ign_latency: got %0d expected 9", lat); end
        checks++; if (product !== 16'h008F) begin errors++; $display("FAIL ign_accum_product: got %h expected 008f", product); end
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ign_done_start: got ready=%b busy=%b expected 1/0", ready, busy); end
        @(negedge clk);
        checks++; if (ready !== 1'b1 || product !== 16'h008F) begin errors++; $display("FAIL ign_no_queue: got ready=%b product=%h expected 1/008f", ready, product); end
    endtask

    task automatic test_back_to_back;
        int dn [$];
        int bad_p;
        bad_p = 0;
        @(negedge clk);
        a = 8'd3; b = 8'd5; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                dn.push_back(n);
                if (product !== 16'h000F) bad_p++;
            end
        end
        start = 1'b0;
        checks++; if (dn.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", dn.size()); end
        if (dn.size() > 0) begin
            checks++; if (dn[0] !== 9) begin errors++; $display("FAIL b2b_first: got %0d expected 9", dn[0]); end
        end
        for (int i = 1; i < dn.size(); i++) begin
            checks++; if (dn[i] - dn[i-1] !== 10) begin errors++; $display("FAIL b2b_period: got %0d expected 10", dn[i] - dn[i-1]); end
        end
        checks++; if (bad_p !== 0) begin errors++; $display("FAIL b2b_product: got %0d wrong products expected 0", bad_p); end
        for (int n = 0; n < 20 && !ready; n++) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: got ready=%b expected 1", ready); end
    endtask

    task automatic test_async_reset;
        int lat, eb, ac; logic [15:0] p; logic [7:0] pbs;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        // Rows 0..3 of FF*FF accumulated: FF * 0xF
        checks++; if (busy !== 1'b1 || product !== 16'h0EF1) begin errors++; $display("FAIL ar_mid: got busy=%b product=%h expected 1/0ef1", busy, product); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ar_state: got ready=%b busy=%b done=%b expected 1/0/0", ready, busy, done); end
        checks++; if (product !== 16'h0) begin errors++; $display("FAIL ar_product: got %h expected 0000", product); end
        checks++; if (ppgen_en !== 1'b0 || ppgen_en_bar !== 1'b1 || pp_a !== 8'h0 || pp_b !== 1'b0) begin
            errors++; $display("FAIL ar_pp: got en=%b bar=%b pp_a=%h pp_b=%b expected 0/1/00/0", ppgen_en, ppgen_en_bar, pp_a, pp_b);
        end
        @(negedge clk);
        rst = 1'b0;
        do_mul(8'd7, 8'd9, lat, p, pbs, eb, ac);
        checks++; if (p !== 16'h003F) begin errors++; $display("FAIL ar_after_product: got %h expected 003f", p); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL ar_after_latency: got %0d expected 9", lat); end
    endtask

    initial begin
        test_reset;
        test_ff;
        test_0d0b;
        test_zero;
        test_ignore_start;
        test_back_to_back;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pp_accum_seq.md
# pp_accum_seq

Sequential shift-and-add multiplier sequencer that sits directly upstream and downstream of the partial-product generator row. Each cycle it drives the row with the latched multiplicand and one broadcast multiplier bit, plus a complementary enable pair. It then consumes the returned partial-product row and accumulates it, shifted, into a 2·WIDTH-bit product. A start/done handshake connects it to the project FSM.

## Interface
- WIDTH, 8, operand width in bits (legal 2..16)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  request a multiply; sampled only when ready=1
- a  in  WIDTH  multiplicand, captured on the accepted start edge
- b  in  WIDTH  multiplier, captured on the accepted start edge
- ready  out  1  high only in IDLE
- busy  out  1  high in ACCUM
- done  out  1  one-cycle pulse in DONE
- product  out  2·WIDTH  result, held from DONE until next accepted start
- pp_a  out  WIDTH  multiplicand to the generator row (the latched a)
- pp_b  out  1  current multiplier bit broadcast to every generator cell
- ppgen_en  out  1  generator row enable
- ppgen_en_bar  out  1  always the exact complement of ppgen_en
- pp_row  in  WIDTH  returned partial-product row; only meaningful while ppgen_en=1

## Operation
- States: IDLE → ACCUM → DONE → IDLE.
- IDLE: ready=1. When start=1 at a clock edge:
  - a_reg←a, b_reg←b, acc←0, idx←0
  - go to ACCUM
- ACCUM: ppgen_en=1, pp_a=a_reg, pp_b=b_reg[idx].
  - Each edge: acc←acc + (zero-extend(pp_row) << idx), idx←idx+1.
  - When idx=WIDTH−1 at the edge, go to DONE instead of incrementing.
- DONE: done=1 and ppgen_en=0. Next edge returns to IDLE.
- product: product is acc. It updates only in ACCUM and is cleared on the accepted start.
- Arithmetic:
  - Unsigned. acc is 2·WIDTH bits; overflow is impossible.
  - idx is ceil(log2(WIDTH)) bits and never wraps.
- Outputs outside ACCUM:
  - ppgen_en=0, ppgen_en_bar=1, pp_b=0.
  - pp_a keeps a_reg; don't-care downstream.
- pp_row sampling: pp_row is never sampled when ppgen_en=0, because the generator output may float.
- start handling:
  - start in ACCUM or DONE is ignored, with no queuing.
  - start held high continuously launches a new multiply on every IDLE cycle.
- Reset (asynchronous, any state, including mid-ACCUM): state=IDLE, a_reg=b_reg=acc=idx=0.
- Output values in reset: ready=1, busy=0, done=0, product=0, ppgen_en=0, ppgen_en_bar=1, pp_a=0, pp_b=0.

## Timing
- All outputs decode from registered state or registers. ppgen_en and ppgen_en_bar come from one state flop plus its inverse, so they never overlap.
- pp_row is combinational from pp_a and pp_b and must settle within the same cycle. It is sampled at the end of that cycle.
- Latency for a start accepted at edge E0:
  - ACCUM covers the cycles after edges E0..E(WIDTH−1).
  - done is high in the cycle after edge E(WIDTH), with product final.
  - The next start can be accepted at edge E(WIDTH+2).
- Throughput: one multiply per WIDTH+2 cycles.

## Structure
- Shared package `pp_pkg`:
  - state enum (IDLE, ACCUM, DONE)
  - DEFAULT_WIDTH constant
  - function for idx width
- Sub-module `pp_acc_reg`: 2·WIDTH-bit shift-add accumulator register, with ports clr, en, pp_row and idx.
- The FSM, operand latches and enable decode remain in the top module.
- The generator row itself is external.

## Test plan
- Reset, then WIDTH=8, a=0xFF, b=0xFF, start one cycle, with the bench modelling pp_row = a & {8{pp_b}} → done pulses exactly 9 cycles after the start edge, with product=0xFE01.
- a=0x0D, b=0x0B → product=0x008F; check pp_b sequence 1,1,0,1,0,0,0,0, and that ppgen_en_bar == ~ppgen_en every cycle.
- a=0x00 and b=0xA5, then a=0xA5 and b=0x00 → product=0x0000 both times, with latency unchanged.
- start pulsed during ACCUM and during DONE → ignored: a/b changes have no effect and product equals the original operands' result.
- start held high with a=3, b=5 → back-to-back multiplies, done every 10 cycles, product=0x000F.
- rst asserted asynchronously mid-ACCUM (idx=4) → all outputs immediately at reset values. A following multiply 7×9 gives 0x003F.
